// File: rtl/nexys4ddr_reset_pkg.sv
// Shared definitions for the Nexys4-DDR staged reset sequencer.
// The state encodings are visible on seq_state for ILA probing.
package nexys4ddr_reset_pkg;

    localparam int unsigned StateW = 3;

    typedef enum logic [StateW-1:0] {
        StHold      = 3'd0,
        StWaitCalib = 3'd1,
        StRelease   = 3'd2,
        StRun       = 3'd3,
        StSoft      = 3'd4
    } seq_state_e;

endpackage

// File: rtl/nexys4ddr_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// It has a synchronous clear so that the latency restarts cleanly after every reset.
module nexys4ddr_sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/nexys4ddr_reset_sequencer.sv
// Staged reset release: wait for DDR calibration, then drop stage resets in order,
// one every STAGE_DELAY cycles. A soft reset re-runs every stage except stage 0.
module nexys4ddr_reset_sequencer
    import nexys4ddr_reset_pkg::*;
#(
    parameter int unsigned STAGES        = 3,
    parameter int unsigned STAGE_DELAY   = 16,
    parameter int unsigned CALIB_TIMEOUT = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              calib_done,
    input  logic              sw_reset_req,
    output logic [STAGES-1:0] stage_reset,
    output logic              all_released,
    output logic              calib_timeout,
    output logic [StateW-1:0] seq_state
);

    localparam int unsigned CntW = $clog2(STAGE_DELAY + 1);
    localparam int unsigned IdxW = $clog2(STAGES + 1);
    localparam int unsigned TmoW = $clog2(CALIB_TIMEOUT + 1);

    localparam logic [CntW-1:0]   CntLast  = CntW'(STAGE_DELAY - 1);
    localparam logic [IdxW-1:0]   IdxLast  = IdxW'(STAGES - 1);
    localparam logic [TmoW-1:0]   TmoLimit = TmoW'(CALIB_TIMEOUT);
    localparam logic [STAGES-1:0] AllOnes  = '1;
    localparam logic [STAGES-1:0] StageOne = STAGES'(1);
    localparam logic [STAGES-1:0] SoftMask = AllOnes & ~StageOne;

    seq_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [STAGES-1:0] stage_reset_q, stage_reset_d;
    logic              all_released_q, all_released_d;
    logic              calib_timeout_q, calib_timeout_d;
    logic              calib_sync;
    logic              release_now;

    nexys4ddr_sync2 u_calib_sync (
        .clock (clock),
        .reset (reset),
        .d     (calib_done),
        .q     (calib_sync)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= StHold;
            cnt_q           <= '0;
            idx_q           <= '0;
            tmo_cnt_q       <= '0;
            stage_reset_q   <= AllOnes;
            all_released_q  <= 1'b0;
            calib_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            tmo_cnt_q       <= tmo_cnt_d;
            stage_reset_q   <= stage_reset_d;
            all_released_q  <= all_released_d;
            calib_timeout_q <= calib_timeout_d;
        end
    end

    // Calibration loss outranks everything in the active states.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        tmo_cnt_d   = tmo_cnt_q;
        release_now = 1'b0;
        case (state_q)
            StHold: state_d = StWaitCalib;
            StWaitCalib: begin
                if (tmo_cnt_q != TmoLimit) tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (calib_sync) begin
                    state_d = StRelease;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            StRelease: begin
                if (!calib_sync) begin
                    state_d = StWaitCalib;
                end else if (cnt_q == CntLast) begin
                    release_now = 1'b1;
                    cnt_d       = '0;
                    idx_d       = idx_q + 1'b1;
                    if (idx_q == IdxLast) state_d = StRun;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!calib_sync) begin
                    state_d = StWaitCalib;
                end else if (sw_reset_req) begin
                    state_d = StSoft;
                    cnt_d   = '0;
                end
            end
            StSoft: begin
                if (!calib_sync) begin
                    state_d = StWaitCalib;
                end else if (cnt_q == CntLast) begin
                    state_d = StRelease;
                    idx_d   = IdxW'(1);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StHold;
        endcase
        if (state_d == StWaitCalib && state_q != StWaitCalib) tmo_cnt_d = '0;
    end

    always_comb begin
        stage_reset_d = stage_reset_q;
        case (state_d)
            StHold, StWaitCalib: stage_reset_d = AllOnes;
            StSoft: if (state_q == StRun) stage_reset_d = SoftMask;
            default: if (release_now) stage_reset_d = stage_reset_q & ~(StageOne << idx_q);
        endcase
        all_released_d  = (state_d == StRun);
        calib_timeout_d = calib_timeout_q | ((state_q == StWaitCalib) && (tmo_cnt_d == TmoLimit));
    end

    assign stage_reset   = stage_reset_q;
    assign all_released  = all_released_q;
    assign calib_timeout = calib_timeout_q;
    assign seq_state     = state_q;

endmodule

// File: doc/nexys4ddr_reset_sequencer.md
# nexys4ddr_reset_sequencer

Staged reset release for the Nexys4-DDR shell, directly downstream of the clock-domain reset generator. It consumes the debounced, synchronized reset of the core clock domain, waits for DDR calibration, then deasserts per-subsystem resets in fixed order with a programmable gap (interconnect/memory first, then peripherals, then the core complex). It re-enters reset on calibration loss and supports a debug-module soft reset that spares stage 0.

## Interface
- `STAGES`, 3: number of staged reset outputs; ≥2; stage 0 is released first.
- `STAGE_DELAY`, 16: cycles between successive releases; ≥1.
- `CALIB_TIMEOUT`, 1000000: cycles in WAIT_CALIB before `calib_timeout` is flagged; ≥1.
- `clock`  in  1  core domain clock.
- `reset`  in  1  synchronous, active-high; driven by the upstream reset generator's output for this domain.
- `calib_done`  in  1  MIG calibration complete; asynchronous, synchronized internally.
- `sw_reset_req`  in  1  soft reset request (debug ndreset), synchronous to `clock`, level-sampled.
- `stage_reset`  out  STAGES  per-stage active-high reset, registered.
- `all_released`  out  1  high only in RUN, registered.
- `calib_timeout`  out  1  sticky: calibration exceeded `CALIB_TIMEOUT`.
- `seq_state`  out  3  current state encoding, for debug/ILA.

## Operation
- `reset`=1 (at each edge): state HOLD, `stage_reset` all ones, `all_released` 0, `calib_timeout` 0, all counters 0, synchronizer flops 0.
- States/encodings: HOLD=0, WAIT_CALIB=1, RELEASE=2, RUN=3, SOFT=4. Other encodings go to HOLD.
- HOLD → WAIT_CALIB unconditionally on the first edge with `reset`=0.
- WAIT_CALIB: all stages held. Timeout counter increments per cycle, saturating. When it reaches `CALIB_TIMEOUT`, set `calib_timeout`; the block keeps waiting. When synchronized `calib_done`=1, go to RELEASE with stage index 0 and delay count 0.
- RELEASE: if count==`STAGE_DELAY`-1, clear `stage_reset[idx]`, increment idx, and reset count to 0; otherwise increment count. Releasing the last stage goes to RUN.
- RUN: `all_released`=1.
  - Synchronized `calib_done`=0: assert all stages and go to WAIT_CALIB.
  - Otherwise, `sw_reset_req`=1: assert `stage_reset[STAGES-1:1]`, leave stage 0 low, go to SOFT with count 0.
- SOFT: hold for `STAGE_DELAY` cycles, then go to RELEASE with idx=1 and count 0.
- Calibration loss in RELEASE or SOFT: assert all stages and go to WAIT_CALIB. This takes priority over everything except `reset`.
- `sw_reset_req` is ignored outside RUN.
- The timeout counter is cleared on every entry to WAIT_CALIB. `calib_timeout` is cleared only by `reset`.
- Delay counter width is clog2(`STAGE_DELAY`+1). Stage index width is clog2(`STAGES`+1).

## Timing
- `calib_done` synchronizer latency is 2 edges.
- Edge 0 is the first edge with `reset`=0, with `calib_done` already high:
  - Edge 0: WAIT_CALIB.
  - Edge 2: RELEASE.
  - Stage k falls at edge 2+(k+1)·`STAGE_DELAY`.
  - The last stage, `all_released`, and RUN all change on the same edge.
- Soft request sampled in RUN at edge t:
  - Stages ≥1 rise and `all_released` falls at edge t.
  - RELEASE is entered at t+`STAGE_DELAY`.
  - Stage k≥1 falls at t+(k+1)·`STAGE_DELAY`.
- `calib_done` falling at the input reaches `stage_reset` all-ones within 3 edges.
- `reset` asserted mid-sequence: all outputs take reset values at that edge.

## Structure
- Package `nexys4ddr_reset_pkg` holds the state enum/encodings and the 3-bit state width.
- Sub-module `nexys4ddr_sync2` is a 2-flop synchronizer with synchronous reset to 0, used for `calib_done`.
- FSM, counters, and output registers live in the top module.

## Test plan
- Power-up: `STAGES`=3, `STAGE_DELAY`=16, `calib_done`=1, release `reset` at edge 0.
  - Required: `stage_reset` goes 111→110 @18, →100 @34, →000 @50; `all_released`=1 @50; `seq_state` 0→1→2→3.
- Timeout: `CALIB_TIMEOUT`=64, `calib_done`=0.
  - Required: `calib_timeout` rises after 64 cycles in WAIT_CALIB and stays high.
  - Raise `calib_done` → normal release; `calib_timeout` still 1.
- Soft reset: 1-cycle `sw_reset_req` in RUN at edge t.
  - Required: `stage_reset`=110 @t, 100 @t+32, 000 @t+48; stage 0 never rises.
- Calibration loss mid-RELEASE, after stage 0 has released:
  - Required: all stages back to 111 within 3 edges, state WAIT_CALIB, timeout counter restarted.
- Simultaneous events: `calib_done` drop and `sw_reset_req` in the same RUN cycle.
  - Required: state goes to WAIT_CALIB, not SOFT.
- `STAGE_DELAY`=1, and `reset` pulsed mid-RELEASE.
  - Required: stages release on consecutive edges.
  - On the `reset` pulse, all outputs return to their reset values on that edge.
